// File: rtl/match_if.sv
// match_if: button/point inputs and game-control outputs of the match controller
interface match_if #(
    parameter int SCORE_W = 3,
    parameter int LEVEL_W = 3
) ();
    logic               start;
    logic               pause;
    logic               point1;
    logic               point2;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [LEVEL_W-1:0] level;
    logic               game_on;
    logic               ball_rst_n;
    logic               serve_dir;
    logic               lvl_up;
    logic               win;
    logic               winner;
    logic [2:0]         fsm_state;

    modport master (
        output start, pause, point1, point2,
        input  score1, score2, level, game_on, ball_rst_n, serve_dir, lvl_up, win, winner, fsm_state
    );

    modport slave (
        input  start, pause, point1, point2,
        output score1, score2, level, game_on, ball_rst_n, serve_dir, lvl_up, win, winner, fsm_state
    );
endinterface

// File: rtl/match_controller.sv
// match_controller: Pong match/level sequencer owning scores, level, serve hold-off, pause and match end
module match_controller #(
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int LEVEL_W     = 3,
    parameter int MAX_LEVEL   = 7,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int CNT_W       = $clog2(SERVE_DELAY + 1)
) (
    input logic   clk,
    input logic   reset,
    match_if.slave m
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        MATCH_END = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]   RELOAD  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

    state_t             state_q, state_d, saved_q, saved_d, serve_next;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d, inc1, inc2;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               game_on_q, game_on_d, ball_rst_n_q, ball_rst_n_d;
    logic               serve_dir_q, serve_dir_d, lvl_up_q, lvl_up_d;
    logic               win_q, win_d, winner_q, winner_d;
    logic               start_prev_q, pause_prev_q;
    logic               start_edge, pause_edge, p1, p2;

    assign start_edge = m.start & ~start_prev_q;
    assign pause_edge = m.pause & ~pause_prev_q;
    assign p1         = m.point1 & ~m.point2;
    assign p2         = m.point2 & ~m.point1;
    assign inc1       = score1_q + SCORE_W'(1);
    assign inc2       = score2_q + SCORE_W'(1);
    assign serve_next = (cnt_q == '0) ? PLAY : SERVE;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            IDLE, GAME_OVER: if (start_edge) begin
                score1_d = '0;
                score2_d = '0;
                level_d  = '0;
                winner_d = 1'b0;
                cnt_d    = RELOAD;
                state_d  = SERVE;
            end
            SERVE: begin
                // the cycle that sees the pause edge still counts as a serve cycle
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                saved_d = pause_edge ? serve_next : saved_q;
                state_d = pause_edge ? PAUSED : serve_next;
            end
            PLAY: if (m.point1 || m.point2) begin
                cnt_d       = RELOAD;
                state_d     = SERVE;
                score1_d    = p1 ? inc1 : score1_q;
                score2_d    = p2 ? inc2 : score2_q;
                serve_dir_d = p1 ? 1'b1 : p2 ? 1'b0 : serve_dir_q;
                if ((p1 && inc1 == WIN) || (p2 && inc2 == WIN)) begin
                    state_d  = MATCH_END;
                    winner_d = p2;
                end
            end else if (pause_edge) begin
                saved_d = PLAY;
                state_d = PAUSED;
            end
            PAUSED: state_d = pause_edge ? saved_q : PAUSED;
            MATCH_END: if (level_q < MAX_LVL) begin
                level_d  = level_q + LEVEL_W'(1);
                score1_d = '0;
                score2_d = '0;
                cnt_d    = RELOAD;
                state_d  = SERVE;
            end else begin
                state_d = GAME_OVER;
            end
            default: state_d = IDLE;
        endcase
        game_on_d    = (state_d == SERVE) || (state_d == PLAY);
        ball_rst_n_d = (state_d == PLAY) || ((state_d == PAUSED) && ball_rst_n_q);
        win_d        = (state_d == MATCH_END);
        lvl_up_d     = (state_d == MATCH_END) && (level_q < MAX_LVL);
    end

    // button edge detectors reset high so a button held through reset is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            saved_q      <= IDLE;
            score1_q     <= '0;
            score2_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            game_on_q    <= 1'b0;
            ball_rst_n_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            lvl_up_q     <= 1'b0;
            win_q        <= 1'b0;
            winner_q     <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            game_on_q    <= game_on_d;
            ball_rst_n_q <= ball_rst_n_d;
            serve_dir_q  <= serve_dir_d;
            lvl_up_q     <= lvl_up_d;
            win_q        <= win_d;
            winner_q     <= winner_d;
            start_prev_q <= m.start;
            pause_prev_q <= m.pause;
        end
    end

    assign m.score1     = score1_q;
    assign m.score2     = score2_q;
    assign m.level      = level_q;
    assign m.game_on    = game_on_q;
    assign m.ball_rst_n = ball_rst_n_q;
    assign m.serve_dir  = serve_dir_q;
    assign m.lvl_up     = lvl_up_q;
    assign m.win        = win_q;
    assign m.winner     = winner_q;
    assign m.fsm_state  = state_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: table-driven check of match_controller with WIN_SCORE=3, MAX_LEVEL=1, SERVE_DELAY=4
module tb_match_controller;
    typedef struct packed {
        logic [2:0] st;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] lv;
        logic       go;
        logic       brn;
        logic       sd;
        logic       lu;
        logic       win;
        logic       wnr;
    } out_t;

    typedef struct packed {
        logic [3:0] in;
        out_t       o;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    match_if #(.SCORE_W(3), .LEVEL_W(3)) m ();

    match_controller #(
        .SCORE_W(3), .WIN_SCORE(3), .LEVEL_W(3), .MAX_LEVEL(1), .SERVE_DELAY(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m(m)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        return '{m.fsm_state, m.score1, m.score2, m.level, m.game_on, m.ball_rst_n,
                 m.serve_dir, m.lvl_up, m.win, m.winner};
    endfunction

    task automatic check(input string name, input out_t e);
        out_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got st=%0d s1=%0d s2=%0d lv=%0d go=%b brn=%b sd=%b lu=%b win=%b wnr=%b exp st=%0d s1=%0d s2=%0d lv=%0d go=%b brn=%b sd=%b lu=%b win=%b wnr=%b",
                     name, a.st, a.s1, a.s2, a.lv, a.go, a.brn, a.sd, a.lu, a.win, a.wnr,
                     e.st, e.s1, e.s2, e.lv, e.go, e.brn, e.sd, e.lu, e.win, e.wnr);
        end
    endtask

    task automatic step(input logic [3:0] in);
        @(negedge clk);
        {m.start, m.pause, m.point1, m.point2} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic [3:0] in, input int st, s1, s2, lv,
                       input logic go, brn, sd, lu, win, wnr);
        for (int i = 0; i < n; i++)
            tbl.push_back('{in, '{3'(st), 3'(s1), 3'(s2), 3'(lv), go, brn, sd, lu, win, wnr}});
    endtask

    task automatic wait_play();
        int n = 0;
        while (m.fsm_state != 3'd2 && n < 20) begin
            step(4'b0000);
            n++;
        end
        checks++;
        if (m.fsm_state != 3'd2) begin
            errors++;
            $display("FAIL wait_play got st=%0d exp st=2 within 20 cycles", m.fsm_state);
        end
    endtask

    initial begin
        {m.start, m.pause, m.point1, m.point2} = 4'b1000;
        // start held through reset, then released and pulsed
        add(1, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(3, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // player 1 wins level 0
        add(1, 4'b0010, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        add(3, 4'b0000, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        add(1, 4'b0010, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0);
        add(3, 4'b0000, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 2, 2, 0, 0, 1, 1, 1, 0, 0, 0);
        add(1, 4'b0010, 4, 3, 0, 0, 0, 0, 1, 1, 1, 0);
        add(1, 4'b0000, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(3, 4'b0000, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        // simultaneous points: let
        add(1, 4'b0011, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(3, 4'b0000, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        // player 2 wins final level
        add(1, 4'b0001, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(3, 4'b0000, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        add(1, 4'b0001, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        add(3, 4'b0000, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 2, 1, 1, 1, 0, 0, 0, 0);
        add(1, 4'b0001, 4, 0, 3, 1, 0, 0, 0, 0, 1, 1);
        add(1, 4'b0000, 5, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        add(1, 4'b0010, 5, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        add(1, 4'b1000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // pause after two serve cycles, ten paused cycles, resume
        add(1, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0100, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0100, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0010, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0001, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1000, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(5, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0100, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", '0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in);
            check($sformatf("vec%0d", i), tbl[i].o);
        end

        // reach level 1 with score1=2 in PLAY, then reset asynchronously
        repeat (3) begin
            step(4'b0010);
            wait_play();
        end
        repeat (2) begin
            step(4'b0010);
            wait_play();
        end
        check("lvl1_score2", '{3'd2, 3'd2, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        #1 reset = 1'b0;
        #1 check("async_reset", '0);
        #1 reset = 1'b1;
        step(4'b0000);
        check("idle_after_reset", '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/match_controller.md
# match_controller

Parametrised match/level sequencer for the Pong top level. It replaces the ad-hoc reset/level logic with an explicit state machine. It owns both score registers, the level counter, the serve hold-off, pause, and end-of-match handling. It sits between the ball engine's point pulses and the ball, paddle, score/LCD and audio blocks, driving their run and reset controls.

## Interface
Parameters:
- SCORE_W, 3: width of each score register.
- WIN_SCORE, 7: score that ends a match; legal range 1..2^SCORE_W-1.
- LEVEL_W, 3: width of the level counter.
- MAX_LEVEL, 7: last level; winning at this level ends the game; at most 2^LEVEL_W-1.
- SERVE_DELAY, 50_000_000: clk cycles the ball is held before each serve; must be ≥1.
- CNT_W, $clog2(SERVE_DELAY+1): serve counter width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low.
- start  in  1  start/restart button; synchronous and debounced; active on rising edge.
- pause  in  1  pause toggle; synchronous and debounced; active on rising edge.
- point1  in  1  one-cycle pulse: player 1 scored.
- point2  in  1  one-cycle pulse: player 2 scored.
- score1  out  SCORE_W  player 1 score.
- score2  out  SCORE_W  player 2 score.
- level  out  LEVEL_W  current level, starting at 0.
- game_on  out  1  paddles and ball may move.
- ball_rst_n  out  1  active-low hold/centre for the ball.
- serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2.
- lvl_up  out  1  one-cycle pulse on level advance.
- win  out  1  one-cycle pulse on match end.
- winner  out  1  0 = player 1, 1 = player 2; valid from the win pulse until the next match.
- fsm_state  out  3  state encoding, for debug.

## Operation
- All outputs are registered, Moore style.
- Reset values:
  - state IDLE; score1 = score2 = 0; level = 0.
  - game_on 0; ball_rst_n 0; serve_dir 0; lvl_up 0; win 0; winner 0; serve counter 0.
  - The edge-detect flops for start and pause reset to 1. A button held through reset therefore does not trigger.
- States (encoding in parentheses):
  - IDLE (0): game_on 0, ball_rst_n 0. A start edge clears the scores and level, loads the counter with SERVE_DELAY-1, and moves to SERVE.
  - SERVE (1): game_on 1, ball_rst_n 0. The counter decrements each cycle. When it reads 0, move to PLAY.
  - PLAY (2): game_on 1, ball_rst_n 1. Point handling:
    - point1 alone: score1+1 and serve_dir=1.
    - point2 alone: score2+1 and serve_dir=0. (The serve goes toward the player who conceded.)
    - If the incremented score equals WIN_SCORE, go to MATCH_END.
    - Otherwise reload the counter and go to SERVE.
    - point1 and point2 in the same cycle: treated as a let. Scores and serve_dir are unchanged; reload the counter and go to SERVE.
  - PAUSED (3): game_on 0. ball_rst_n holds its pre-pause value. The counter freezes and point pulses are ignored. A pause edge returns to the saved state (SERVE or PLAY).
    - A pause edge in SERVE or PLAY enters PAUSED. Pause is ignored in all other states.
  - MATCH_END (4): exactly one cycle. win=1 and winner is set. game_on 0, ball_rst_n 0.
    - If level < MAX_LEVEL: lvl_up=1 this cycle. Next cycle: level+1, scores cleared, counter reloaded, state SERVE.
    - If level == MAX_LEVEL: next state GAME_OVER. Scores and level are held.
  - GAME_OVER (5): game_on 0, ball_rst_n 0. Outputs are frozen. A start edge clears scores, level and winner, reloads the counter, and goes to SERVE.
- A start edge in SERVE, PLAY, PAUSED or MATCH_END is ignored.
- Scores never exceed WIN_SCORE. The level never exceeds MAX_LEVEL.
- Asynchronous reset in any state returns to the reset values immediately, including mid-serve or mid-pause.

## Timing
- A point pulse sampled at edge N gives, at N+1: the updated score, state SERVE (or MATCH_END), and ball_rst_n=0.
- From entry to SERVE, ball_rst_n stays low for exactly SERVE_DELAY cycles, excluding paused cycles. It rises on the following edge.
- Win: MATCH_END at N+1 with win/lvl_up high for that cycle only. At N+2: scores 0, level incremented, state SERVE.
- A start or pause edge at edge N takes effect in state at N+1. The input must be low for ≥1 cycle before a new edge is recognised.
- Point pulses arriving outside PLAY are dropped.

## Test plan
Parameters for all scenarios: WIN_SCORE=3, MAX_LEVEL=1, SERVE_DELAY=4.
1. Reset with start held high; release, then pulse start → no action until the edge. SERVE lasts 4 cycles with ball_rst_n=0, game_on=1, then PLAY with ball_rst_n=1.
2. Three point1 pulses in PLAY → score1 steps 1, 2, 3; serve_dir=1 each time. win=1, lvl_up=1 for one cycle with winner=0. Next cycle: level=1, scores 0/0.
3. At level 1, three point2 pulses → win pulse with winner=1 and no lvl_up. State GAME_OVER with score2=3 held. A start edge then gives level=0, scores 0, SERVE.
4. point1 and point2 asserted together in PLAY → scores unchanged, state SERVE for 4 cycles.
5. Pause edge after 2 serve cycles → game_on=0 and the counter is frozen for 10 cycles with point pulses ignored. Second pause edge → exactly 2 more serve cycles, then PLAY.
6. Assert reset mid-PLAY with score1=2, level=1 → all outputs return to reset values asynchronously and the state is IDLE.
